// File: rtl/execute_muldiv_ctrl.sv
// ----------------------------------------------------------------------------
// execute_muldiv_ctrl
//
// Iterative RV32M multiply/divide sequencer that sits beside the execute-stage
// ALU. An M-extension instruction in EX is accepted when the unit is idle. The
// unit then stalls the front of the pipeline while it iterates, and presents a
// registered result together with a one-cycle done strobe. The EX stage muxes
// md_res onto ma_dat in place of the ALU output while md_done is high.
//
// Parameters:
//   BITS_PER_CYC  multiplier/quotient bits retired per iteration cycle
//                 (1, 2 or 4); N = 32/BITS_PER_CYC iteration cycles.
//
// Optional feature macro:
//   EXECUTE_MULDIV_FAST_MUL_EN  when defined, every multiply completes through
//                 one combinational 33x33 signed multiplier (result at T+1).
//                 Division is always iterative.
//
// Ports:
//   clk       in   core clock
//   rst_n     in   asynchronous active-low reset
//   ex_vld    in   EX stage holds a valid instruction
//   ex_inst   in   EX instruction word
//   ex_dat_a  in   rs1 operand
//   ex_dat_b  in   rs2 operand
//   ex_flush  in   kill the EX instruction / abort the in-flight operation
//   ex_stall  out  hold IF/ID/EX registers this cycle
//   md_done   out  md_res is valid this cycle (single-cycle pulse)
//   md_res    out  multiply/divide result, held until the next completion
//
// Handshake: an M instruction is taken in the cycle where ex_vld=1,
// ex_flush=0 and the unit is IDLE. ex_stall is high in that cycle and in
// every BUSY cycle, so EX keeps presenting the same instruction. In the DONE
// cycle ex_stall is low and md_done is high; the pipeline advances at the end
// of that cycle, carrying md_res. The instruction still in EX during DONE is
// the one just completed, so it is not re-accepted.
// ----------------------------------------------------------------------------
module execute_muldiv_ctrl #(
    parameter int BITS_PER_CYC = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_vld,
    input  logic [31:0] ex_inst,
    input  logic [31:0] ex_dat_a,
    input  logic [31:0] ex_dat_b,
    input  logic        ex_flush,
    output logic        ex_stall,
    output logic        md_done,
    output logic [31:0] md_res
);

    localparam int         N        = 32 / BITS_PER_CYC;
    localparam logic [4:0] CNT_LOAD = 5'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q,   cnt_d;
    logic [2:0]  op_q,    op_d;
    // Multiply: acc = running product, opa = multiplicand (shifts left),
    //           opb = multiplier (shifts right).
    // Divide:   acc[32:0] = partial remainder, opa[31:0] = dividend bits
    //           shifting out / quotient bits shifting in, opb = divisor.
    logic [63:0] acc_q,   acc_d;
    logic [63:0] opa_q,   opa_d;
    logic [31:0] opb_q,   opb_d;
    logic        neg_q,   neg_d;    // negate product / quotient
    logic        rneg_q,  rneg_d;   // negate remainder
    logic [31:0] res_q,   res_d;

    // ------------------------------------------------------------------
    // Decode and operand preparation at accept
    // ------------------------------------------------------------------
    logic [2:0]  f3;
    logic        is_m;
    logic        is_mul;
    logic        start;
    logic        a_signed, b_signed;
    logic        sa, sb;
    logic [31:0] mag_a, mag_b;

    assign f3     = ex_inst[14:12];
    assign is_m   = (ex_inst[6:0] == 7'b0110011) && (ex_inst[31:25] == 7'b0000001);
    assign is_mul = ~f3[2];
    assign start  = ex_vld & ~ex_flush & is_m & (state_q == S_IDLE);

    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        if (is_mul) begin
            a_signed = (f3 == 3'd1) || (f3 == 3'd2);   // MULH, MULHSU
            b_signed = (f3 == 3'd1);                   // MULH only
        end else begin
            a_signed = ~f3[0];                         // DIV, REM
            b_signed = ~f3[0];
        end
    end

    assign sa    = a_signed & ex_dat_a[31];
    assign sb    = b_signed & ex_dat_b[31];
    assign mag_a = sa ? (32'd0 - ex_dat_a) : ex_dat_a;
    assign mag_b = sb ? (32'd0 - ex_dat_b) : ex_dat_b;

    // Division corner cases resolve without iterating.
    logic        div_zero, div_ovf, div_fast;
    logic [31:0] div_fast_res;

    assign div_zero = ~is_mul & (ex_dat_b == 32'd0);
    assign div_ovf  = ~is_mul & ~f3[0] & (ex_dat_a == 32'h8000_0000) &
                      (ex_dat_b == 32'hFFFF_FFFF);
    assign div_fast = div_zero | div_ovf;

    always_comb begin
        div_fast_res = 32'd0;
        if (div_zero) begin
            div_fast_res = f3[1] ? ex_dat_a : 32'hFFFF_FFFF;
        end else begin
            div_fast_res = f3[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    // ------------------------------------------------------------------
    // Single-cycle multiply option
    // ------------------------------------------------------------------
    logic        mul_fast;
    logic [31:0] fm_res;

`ifdef EXECUTE_MULDIV_FAST_MUL_EN
    // The 33rd bit carries the operand's signedness, so one signed
    // multiplier covers MUL, MULH, MULHSU and MULHU. It is evaluated on the
    // operands being accepted and registered straight into res_q.
    logic signed [32:0] fm_a, fm_b;
    logic signed [65:0] fm_p;
    logic               unused_fm;

    assign fm_a      = {a_signed & ex_dat_a[31], ex_dat_a};
    assign fm_b      = {b_signed & ex_dat_b[31], ex_dat_b};
    assign fm_p      = fm_a * fm_b;
    assign fm_res    = (f3 == 3'd0) ? fm_p[31:0] : fm_p[63:32];
    assign mul_fast  = is_mul;
    assign unused_fm = ^fm_p[65:64];
`else
    assign fm_res   = 32'd0;
    assign mul_fast = 1'b0;
`endif

    // ------------------------------------------------------------------
    // One iteration step (BITS_PER_CYC bits)
    // ------------------------------------------------------------------
    logic [63:0] mul_acc;
    logic [32:0] div_rem;
    logic [31:0] div_quo;

    always_comb begin
        mul_acc = acc_q;
        for (int i = 0; i < BITS_PER_CYC; i++) begin
            if (opb_q[i]) begin
                mul_acc = mul_acc + (opa_q << i);
            end
        end

        div_rem = acc_q[32:0];
        div_quo = opa_q[31:0];
        for (int i = 0; i < BITS_PER_CYC; i++) begin
            div_rem = {div_rem[31:0], div_quo[31]};
            div_quo = {div_quo[30:0], 1'b0};
            if (div_rem >= {1'b0, opb_q}) begin
                div_rem    = div_rem - {1'b0, opb_q};
                div_quo[0] = 1'b1;
            end
        end
    end

    // Final sign fix-up, taken from the last step's outputs so the result
    // can be registered on the BUSY->DONE edge.
    logic [63:0] prod_fin;
    logic [31:0] quo_fin, rem_fin, iter_res;

    always_comb begin
        prod_fin = neg_q  ? (64'd0 - mul_acc)       : mul_acc;
        quo_fin  = neg_q  ? (32'd0 - div_quo)       : div_quo;
        rem_fin  = rneg_q ? (32'd0 - div_rem[31:0]) : div_rem[31:0];
        if (op_q[2]) begin
            iter_res = op_q[1] ? rem_fin : quo_fin;
        end else begin
            iter_res = (op_q == 3'd0) ? prod_fin[31:0] : prod_fin[63:32];
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        acc_d   = acc_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        res_d   = res_q;

        // A flush in BUSY releases the pipeline in the same cycle.
        ex_stall = start | ((state_q == S_BUSY) & ~ex_flush);
        md_done  = (state_q == S_DONE) & ~ex_flush;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d   = f3;
                    acc_d  = 64'd0;
                    opa_d  = {32'd0, mag_a};
                    opb_d  = mag_b;
                    neg_d  = sa ^ sb;
                    rneg_d = sa;
                    if (div_fast) begin
                        state_d = S_DONE;
                        res_d   = div_fast_res;
                    end else if (mul_fast) begin
                        state_d = S_DONE;
                        res_d   = fm_res;
                    end else begin
                        state_d = S_BUSY;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end

            S_BUSY: begin
                if (ex_flush) begin
                    state_d = S_IDLE;
                    cnt_d   = 5'd0;
                end else begin
                    if (op_q[2]) begin
                        acc_d = {31'd0, div_rem};
                        opa_d = {32'd0, div_quo};
                    end else begin
                        acc_d = mul_acc;
                        opa_d = opa_q << BITS_PER_CYC;
                        opb_d = opb_q >> BITS_PER_CYC;
                    end
                    if (cnt_q == 5'd0) begin
                        state_d = S_DONE;
                        res_d   = iter_res;
                    end else begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            op_q    <= 3'd0;
            acc_q   <= 64'd0;
            opa_q   <= 64'd0;
            opb_q   <= 32'd0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            res_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            res_q   <= res_d;
        end
    end

    assign md_res = res_q;

    // Register-address fields of the instruction play no part here.
    logic unused_inst;
    assign unused_inst = ^{ex_inst[24:15], ex_inst[11:7]};

endmodule

// File: tb/tb_execute_muldiv_ctrl.sv
// ----------------------------------------------------------------------------
// tb_execute_muldiv_ctrl
//
// Self-checking bench for execute_muldiv_ctrl (BITS_PER_CYC = 1, N = 32).
// Expected results come from an arithmetic model of the RV32M instructions
// (64-bit products, integer division with the RISC-V corner-case rules);
// expected timing comes from the accept/latency rules: N+1 cycles to DONE,
// or 1 cycle for the division corner cases (and every multiply when
// EXECUTE_MULDIV_FAST_MUL_EN is defined).
// ----------------------------------------------------------------------------
module tb_execute_muldiv_ctrl;

    localparam int N = 32;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        ex_vld   = 1'b0;
    logic [31:0] ex_inst  = 32'd0;
    logic [31:0] ex_dat_a = 32'd0;
    logic [31:0] ex_dat_b = 32'd0;
    logic        ex_flush = 1'b0;
    logic        ex_stall;
    logic        md_done;
    logic [31:0] md_res;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_res  = 32'd0;
    bit          res_known = 1'b1;

    execute_muldiv_ctrl #(.BITS_PER_CYC(1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ex_vld   (ex_vld),
        .ex_inst  (ex_inst),
        .ex_dat_a (ex_dat_a),
        .ex_dat_b (ex_dat_b),
        .ex_flush (ex_flush),
        .ex_stall (ex_stall),
        .md_done  (md_done),
        .md_res   (md_res)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_md(input logic [2:0] f3,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
        longint      sa, sb, ua, ub, q;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        p  = 64'd0;
        q  = 0;
        case (f3)
            3'd0: begin p = 64'(sa * sb); return p[31:0];  end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                q = sa / sb; p = 64'(q); return p[31:0];
            end
            3'd5: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                q = ua / ub; p = 64'(q); return p[31:0];
            end
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                q = sa % sb; p = 64'(q); return p[31:0];
            end
            default: begin
                if (b == 32'd0) return a;
                q = ua % ub; p = 64'(q); return p[31:0];
            end
        endcase
    endfunction

    // Cycles from accept (T) to the DONE cycle.
    function automatic int ref_lat(input logic [2:0] f3,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        if (f3[2] && (b == 32'd0 ||
            (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
`ifdef EXECUTE_MULDIV_FAST_MUL_EN
        if (!f3[2]) return 1;
`endif
        return N + 1;
    endfunction

    function automatic logic [31:0] mk_inst(input logic [2:0] f3);
        return {7'b0000001, 5'($urandom), 5'($urandom), f3, 5'($urandom), 7'b0110011};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(1, 9));
            default: return $urandom;
        endcase
    endfunction

    // ---------------- checks ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic got, input logic exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Presents one M instruction from cycle T and holds it while stalled,
    // scrambling the operand buses after accept. flush_at (cycle offset from T,
    // >= 1) raises ex_flush for one cycle; -1 means no flush.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input int flush_at);
        int          lat;
        logic [31:0] exp;
        bit          flushed;
        lat = ref_lat(f3, a, b);
        exp_q.push_back(ref_md(f3, a, b));
        flushed  = 1'b0;
        ex_vld   = 1'b1;
        ex_inst  = mk_inst(f3);
        ex_dat_a = a;
        ex_dat_b = b;
        ex_flush = 1'b0;
        for (int c = 0; c <= lat; c++) begin
            if (c == flush_at) ex_flush = 1'b1;
            @(negedge clk);
            if (c == flush_at) begin
                exp = exp_q.pop_front();
                check_bit("stall_on_flush", ex_stall, 1'b0);
                check_bit("done_on_flush", md_done, 1'b0);
                flushed = 1'b1;
                if (c == lat) begin
                    // Result register was loaded on entry to DONE.
                    last_res  = exp;
                    res_known = 1'b0;
                end
            end else if (c < lat) begin
                check_bit("stall_busy", ex_stall, 1'b1);
                check_bit("done_early", md_done, 1'b0);
            end else begin
                exp = exp_q.pop_front();
                check_bit("stall_in_done", ex_stall, 1'b0);
                check_bit("done_pulse", md_done, 1'b1);
                check("md_res", md_res, exp);
                last_res  = exp;
                res_known = 1'b1;
            end
            @(posedge clk);
            #1;
            ex_flush = 1'b0;
            if (flushed) break;
            ex_dat_a = $urandom;
            ex_dat_b = $urandom;
        end
        ex_vld = 1'b0;
        if (flushed) begin
            @(negedge clk);
            check_bit("done_after_flush", md_done, 1'b0);
            check_bit("stall_after_flush", ex_stall, 1'b0);
            if (res_known) check("res_hold_flush", md_res, last_res);
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset state
        #2;
        check_bit("rst_done", md_done, 1'b0);
        check("rst_res", md_res, 32'd0);
        check_bit("rst_stall", ex_stall, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Test plan 1-4
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, -1);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, -1);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, -1);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, -1);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, -1);
        run_op(3'd5, 32'd100, 32'd7, -1);
        run_op(3'd7, 32'd100, 32'd7, -1);
        run_op(3'd5, 32'd5, 32'd0, -1);
        run_op(3'd7, 32'd5, 32'd0, -1);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, -1);

        // Test plan 5: back-to-back, then flush in BUSY cycle 10
        run_op(3'd4, 32'd1000, 32'hFFFF_FFFD, -1);
        run_op(3'd0, 32'h0001_0001, 32'h0000_FFFF, -1);
        run_op(3'd5, 32'hDEAD_BEEF, 32'd3, 10);
        run_op(3'd0, 32'd5, 32'd6, -1);

        // Non-M instruction and flush in IDLE never start the unit
        ex_vld  = 1'b1;
        ex_inst = 32'h0020_81B3;              // add x3, x1, x2
        @(negedge clk);
        check_bit("alu_no_stall", ex_stall, 1'b0);
        ex_inst  = mk_inst(3'd0);
        ex_flush = 1'b1;
        #1;
        check_bit("idle_flush_no_stall", ex_stall, 1'b0);
        @(posedge clk);
        #1;
        ex_vld   = 1'b0;
        ex_flush = 1'b0;
        @(negedge clk);
        check_bit("idle_flush_no_done", md_done, 1'b0);
        check_bit("idle_flush_no_busy", ex_stall, 1'b0);
        @(posedge clk);
        #1;

        // Test plan 6: reset mid-BUSY, then MUL 3*4
        ex_vld   = 1'b1;
        ex_inst  = mk_inst(3'd0);
        ex_dat_a = 32'h1234;
        ex_dat_b = 32'h5678;
        repeat (6) @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_bit("rst_mid_done", md_done, 1'b0);
        check("rst_mid_res", md_res, 32'd0);
        check_bit("rst_mid_stall_start", ex_stall, 1'b1);
        ex_vld = 1'b0;
        #1;
        check_bit("rst_mid_stall", ex_stall, 1'b0);
        @(posedge clk);
        #1;
        check("rst_mid_res_hold", md_res, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        last_res = 32'd0;
        run_op(3'd0, 32'd3, 32'd4, -1);

        // Randomized operations, occasionally flushed in BUSY or DONE
        for (int k = 0; k < 30; k++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            int          lat, fl;
            f3  = 3'($urandom_range(0, 7));
            a   = pick();
            b   = pick();
            lat = ref_lat(f3, a, b);
            fl  = -1;
            if (lat > 1 && $urandom_range(0, 4) == 0) fl = $urandom_range(1, lat);
            run_op(f3, a, b, fl);
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                check_bit("gap_no_done", md_done, 1'b0);
                @(posedge clk);
                #1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
